s_p_deserializer: RTL and testbench
===================================

S_P_DESERIALIZER -- requirements
Module: s_p_deserializer

Interface
REQ-001 Parameter C_BITS_OUT, default 8: width of the assembled parallel word.
REQ-002 Parameter C_LANES, default 1: serial bits accepted per beat; C_BITS_OUT SHALL be an integer multiple of C_LANES.
REQ-003 Parameter C_MSB_FIRST, default 0: 0 = first beat is least significant, 1 = first beat is most significant.
REQ-004 CK  input  1  sole clock, rising-edge active.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 D  input  C_LANES  serial data beat; D[C_LANES-1] is the more significant bit within a beat.
REQ-007 D_VALID  input  1  D carries a valid beat this cycle.
REQ-008 SOF  input  1  start-of-frame, qualified by D_VALID; marks the current beat as beat 0.
REQ-009 Q  output  C_BITS_OUT  assembled parallel word, held stable while Q_VALID=1.
REQ-010 Q_VALID  output  1  Q holds an unconsumed word.
REQ-011 Q_READY  input  1  consumer accepts Q; transfer occurs when Q_VALID && Q_READY at a rising edge.
REQ-012 OVF  output  1  sticky overrun flag.

Function
REQ-013 Let N = C_BITS_OUT/C_LANES; the block SHALL count accepted beats 0..N-1 with a beat counter of ceil(log2(N)) bits, minimum 1 bit.
REQ-014 A beat SHALL be accepted only at a rising edge with D_VALID=1; with D_VALID=0, shift register and counter SHALL hold.
REQ-015 Accumulator states: IDLE (count=0, no partial word) -> ACCUM on an accepted beat when N>1; ACCUM -> IDLE on acceptance of beat N-1; with N=1 every accepted beat completes a word and the state stays IDLE.
REQ-016 With C_MSB_FIRST=0, beat k SHALL occupy Q[k*C_LANES +: C_LANES]; with C_MSB_FIRST=1, beat k SHALL occupy Q[C_BITS_OUT-1-k*C_LANES -: C_LANES].
REQ-017 On the edge accepting beat N-1, the complete word SHALL load into Q and Q_VALID SHALL be 1 after that edge (one-cycle latency from final beat presented to Q_VALID).
REQ-018 Q_VALID SHALL clear on a transfer edge unless a word completes on the same edge, in which case Q loads the new word and Q_VALID stays 1.
REQ-019 If a word completes while Q_VALID=1 and Q_READY=0: the new word SHALL be discarded, Q unchanged, OVF set to 1; OVF stays 1 until reset.
REQ-020 SOF=1 with D_VALID=1 SHALL discard any partial word and treat D as beat 0, from either state; SOF with D_VALID=0 SHALL be ignored.
REQ-021 SOF on a beat that also completes a word (N=1) SHALL complete that word normally.
REQ-022 Counter wrap: after beat N-1 the next accepted beat SHALL be beat 0 without requiring SOF.

Reset
REQ-023 RST=0 SHALL asynchronously force state IDLE, beat counter 0, shift register 0, Q=0, Q_VALID=0, OVF=0.
REQ-024 Reset asserted mid-word SHALL discard the partial word; the first accepted beat after reset deassertion is beat 0.
REQ-025 Deassertion SHALL be synchronised to CK externally; no beat is accepted on the edge coinciding with deassertion.

Structure
REQ-026 Shared package s_p_deserializer_pkg SHALL hold the beat-count-width function and the IDLE/ACCUM state enumeration.
REQ-027 The beat counter SHALL be one sub-module, beat_counter (parameter N; inputs CK, RST, inc, clr; outputs count, last).
REQ-028 Output holding register and handshake logic SHALL reside in the top module.

Verification
REQ-029 C_BITS_OUT=8, C_LANES=1, LSB-first; bits 1,0,1,1,0,0,1,0 on 8 consecutive beats, Q_READY=1 -> Q=8'h4D, Q_VALID=1 for one cycle.
REQ-030 Same stream, C_MSB_FIRST=1 -> Q=8'hB2.
REQ-031 C_BITS_OUT=16, C_LANES=4, LSB-first; beats 4'hA,4'hB,4'hC,4'hD with D_VALID gaps of 2 cycles between beats -> Q=16'hDCBA after the last beat only.
REQ-032 Q_READY=0; two full 8-bit words 8'h11 then 8'h22 -> Q remains 8'h11, OVF=1; Q_READY=1 -> transfer, Q_VALID=0, OVF still 1.
REQ-033 Three beats of a word, then SOF beat followed by the rest of a new word 8'h5A -> Q=8'h5A, no partial bits from the aborted word.
REQ-034 RST=0 after 5 beats asynchronously (between edges) -> all outputs 0 immediately; next 8 beats yield correct word.

Source files
------------

// File: rtl/s_p_deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
package s_p_deserializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // Beat counter width: ceil(log2(n)), never narrower than one bit.
    function automatic int beat_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/s_p_deserializer_beat_counter.sv
// Beat index counter 0..N-1 with wrap; clr forces the current beat to index 0.
module beat_counter
    import s_p_deserializer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic                     inc,
    input  logic                     clr,
    output logic [beat_cnt_w(N)-1:0] count,
    output logic                     last
);
    localparam int W = beat_cnt_w(N);

    logic [W-1:0] cnt_q, cnt_d, cur;

    // count/last describe the beat presented now, so a start-of-frame beat is index 0.
    assign cur   = clr ? '0 : cnt_q;
    assign last  = (cur == W'(N - 1));
    assign count = cur;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) cnt_d = last ? '0 : cur + W'(1);
    end

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/s_p_deserializer.sv
// Assembles C_LANES-wide serial beats into C_BITS_OUT-wide words with a valid/ready output.
module s_p_deserializer
    import s_p_deserializer_pkg::*;
#(
    parameter int C_BITS_OUT  = 8,
    parameter int C_LANES     = 1,
    parameter int C_MSB_FIRST = 0
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic [C_LANES-1:0]    D,
    input  logic                  D_VALID,
    input  logic                  SOF,
    output logic [C_BITS_OUT-1:0] Q,
    output logic                  Q_VALID,
    input  logic                  Q_READY,
    output logic                  OVF
);
    localparam int N = C_BITS_OUT / C_LANES;
    localparam int W = beat_cnt_w(N);

    acc_state_e            state_q, state_d;
    logic [C_BITS_OUT-1:0] sr_q, sr_d, word;
    logic [C_BITS_OUT-1:0] q_q, q_d;
    logic                  q_valid_q, q_valid_d;
    logic                  ovf_q, ovf_d;
    logic [W-1:0]          idx;
    logic                  last, accept, restart, complete, xfer;
    int                    pos;

    assign accept   = D_VALID;
    assign restart  = D_VALID & SOF;
    assign complete = accept & last;
    assign xfer     = q_valid_q & Q_READY;

    beat_counter #(.N(N)) u_cnt (
        .CK   (CK),
        .RST  (RST),
        .inc  (accept),
        .clr  (restart),
        .count(idx),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        if (accept) state_d = last ? IDLE : ACCUM;
    end

    // Beats are written in place; a restart drops whatever partial word was held.
    always_comb begin
        pos  = (C_MSB_FIRST != 0) ? (N - 1 - int'(idx)) : int'(idx);
        word = restart ? '0 : sr_q;
        word[pos*C_LANES +: C_LANES] = D;
        sr_d = sr_q;
        if (accept) sr_d = last ? '0 : word;
    end

    // A completed word lands only if the holding register is free or draining this edge.
    always_comb begin
        q_d       = q_q;
        q_valid_d = q_valid_q;
        ovf_d     = ovf_q;
        if (complete) begin
            if (!q_valid_q || Q_READY) begin
                q_d       = word;
                q_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (xfer) begin
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Q       = q_q;
    assign Q_VALID = q_valid_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_s_p_deserializer.sv
// Directed bench for three deserializer configurations sharing one clock and reset.
module tb_s_p_deserializer;

    logic        CK = 1'b0;
    logic        RST;
    logic [0:0]  d8;
    logic        dv8, sof8, rdy8;
    logic [3:0]  d16;
    logic        dv16, sof16, rdy16;
    logic [7:0]  q8l, q8m;
    logic [15:0] q16;
    logic        qv8l, qv8m, qv16, ovf8l, ovf8m, ovf16;

    int tests = 0;
    int fails = 0;

    logic [7:0]  sb_l[$];
    logic [7:0]  sb_m[$];
    logic [15:0] sb_16[$];

    always #5 CK = ~CK;

    s_p_deserializer #(.C_BITS_OUT(8), .C_LANES(1), .C_MSB_FIRST(0)) u8l (
        .CK(CK), .RST(RST), .D(d8), .D_VALID(dv8), .SOF(sof8),
        .Q(q8l), .Q_VALID(qv8l), .Q_READY(rdy8), .OVF(ovf8l)
    );

    s_p_deserializer #(.C_BITS_OUT(8), .C_LANES(1), .C_MSB_FIRST(1)) u8m (
        .CK(CK), .RST(RST), .D(d8), .D_VALID(dv8), .SOF(sof8),
        .Q(q8m), .Q_VALID(qv8m), .Q_READY(rdy8), .OVF(ovf8m)
    );

    s_p_deserializer #(.C_BITS_OUT(16), .C_LANES(4), .C_MSB_FIRST(0)) u16 (
        .CK(CK), .RST(RST), .D(d16), .D_VALID(dv16), .SOF(sof16),
        .Q(q16), .Q_VALID(qv16), .Q_READY(rdy16), .OVF(ovf16)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic beat8(input logic b, input logic s);
        d8[0] = b; dv8 = 1'b1; sof8 = s;
        step();
        dv8 = 1'b0; sof8 = 1'b0;
    endtask

    // Bits go out word[0] first; the MSB-first instance sees the same stream reversed.
    task automatic send8(input logic [7:0] w, input logic push);
        if (push) begin
            sb_l.push_back(w);
            sb_m.push_back(rev8(w));
        end
        for (int k = 0; k < 8; k++) beat8(w[k], 1'b0);
    endtask

    // Scoreboard pop: a word is consumed on each cycle Q_VALID && Q_READY.
    always @(negedge CK) begin
        if (qv8l && rdy8) begin
            chk("8l_word_expected", 16'(sb_l.size() != 0), 16'd1);
            if (sb_l.size() != 0) chk("8l_q", 16'(q8l), 16'(sb_l.pop_front()));
        end
        if (qv8m && rdy8) begin
            chk("8m_word_expected", 16'(sb_m.size() != 0), 16'd1);
            if (sb_m.size() != 0) chk("8m_q", 16'(q8m), 16'(sb_m.pop_front()));
        end
        if (qv16 && rdy16) begin
            chk("16_word_expected", 16'(sb_16.size() != 0), 16'd1);
            if (sb_16.size() != 0) chk("16_q", q16, sb_16.pop_front());
        end
    end

    initial begin
        logic [3:0]  nib [4];
        logic [7:0]  w5a;
        RST = 1'b0;
        d8 = '0; dv8 = 1'b0; sof8 = 1'b0; rdy8 = 1'b0;
        d16 = '0; dv16 = 1'b0; sof16 = 1'b0; rdy16 = 1'b0;
        step(); step();

        chk("rst_q8l", 16'(q8l), 16'h0);
        chk("rst_qv8l", 16'(qv8l), 16'h0);
        chk("rst_ovf8l", 16'(ovf8l), 16'h0);
        chk("rst_q8m", 16'(q8m), 16'h0);
        chk("rst_qv16", 16'(qv16), 16'h0);
        chk("rst_q16", q16, 16'h0);

        RST = 1'b1;
        step();
        rdy8 = 1'b1; rdy16 = 1'b1;

        // 1,0,1,1,0,0,1,0 -> 4D (LSB first) / B2 (MSB first)
        send8(8'h4D, 1'b1);
        chk("lsb_word", 16'(q8l), 16'h004D);
        chk("msb_word", 16'(q8m), 16'h00B2);
        chk("lsb_valid", 16'(qv8l), 16'h1);
        step();
        chk("valid_one_cycle", 16'(qv8l), 16'h0);

        // Second word straight after, no SOF: counter wraps on its own.
        send8(8'h3C, 1'b1);
        step(); step();

        // 16-bit, 4 lanes, two idle cycles between beats.
        nib[0] = 4'hA; nib[1] = 4'hB; nib[2] = 4'hC; nib[3] = 4'hD;
        sb_16.push_back(16'hDCBA);
        for (int b = 0; b < 4; b++) begin
            d16 = nib[b]; dv16 = 1'b1;
            step();
            dv16 = 1'b0;
            if (b < 3) begin
                chk("16_no_early_valid", 16'(qv16), 16'h0);
                step();
                chk("16_gap_hold", 16'(qv16), 16'h0);
                step();
            end
        end
        chk("16_word", q16, 16'hDCBA);
        step(); step();

        // Overrun: second word dropped while first is unconsumed.
        rdy8 = 1'b0;
        send8(8'h11, 1'b1);
        send8(8'h22, 1'b0);
        chk("ovf_q_held", 16'(q8l), 16'h0011);
        chk("ovf_q_held_msb", 16'(q8m), 16'h0088);
        chk("ovf_set", 16'(ovf8l), 16'h1);
        chk("ovf_valid_held", 16'(qv8l), 16'h1);
        rdy8 = 1'b1;
        step();
        chk("ovf_xfer_clears_valid", 16'(qv8l), 16'h0);
        chk("ovf_sticky", 16'(ovf8l), 16'h1);
        chk("ovf_sticky_msb", 16'(ovf8m), 16'h1);
        chk("ovf16_clean", 16'(ovf16), 16'h0);

        // Abort a partial word with SOF, then send 5A.
        for (int k = 0; k < 3; k++) beat8(1'b1, 1'b0);
        w5a = 8'h5A;
        sb_l.push_back(w5a);
        sb_m.push_back(rev8(w5a));
        beat8(w5a[0], 1'b1);
        for (int k = 1; k < 8; k++) beat8(w5a[k], 1'b0);
        chk("sof_word", 16'(q8l), 16'h005A);
        step(); step();

        // Asynchronous reset mid-word, between edges.
        for (int k = 0; k < 5; k++) beat8(1'b1, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_q", 16'(q8l), 16'h0);
        chk("arst_qv", 16'(qv8l), 16'h0);
        chk("arst_ovf", 16'(ovf8l), 16'h0);
        chk("arst_ovf_msb", 16'(ovf8m), 16'h0);
        step();
        RST = 1'b1;
        step();
        send8(8'hC3, 1'b1);
        chk("post_rst_word", 16'(q8l), 16'h00C3);
        step(); step();

        chk("sb_l_drained", 16'(sb_l.size()), 16'd0);
        chk("sb_m_drained", 16'(sb_m.size()), 16'd0);
        chk("sb_16_drained", 16'(sb_16.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
